// File: rtl/proc_pkg.sv
// Shared opcodes, FSM state encodings and instruction field positions for the
// 16-bit processor's sequencer.
package proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_OUT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RA_HI  = 11;
    localparam int RA_LO  = 9;
    localparam int RB_HI  = 8;
    localparam int RB_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/step_divider.sv
// Free-running step divider: one-cycle tick every TICK_DIV clocks while en=1.
// Dropping en clears the count and suppresses a tick in that same cycle.
module step_divider #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_r;

    // Divider count; restarts from zero whenever en is low or the last count is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (!en) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r == LAST) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign tick = en && (count_r == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Four-step FETCH/DECODE/EXEC/WB controller between the instruction ROM and the
// register file, paced by a step divider so the datapath can be watched on a board.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] address,
    output logic [2:0]        reg_a,
    output logic [2:0]        reg_b,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] result,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    state_t            state_r;
    state_t            state_next_s;
    logic              tick_s;
    logic [3:0]        ir_op_r;
    logic [7:0]        ir_imm_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;

    step_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_step_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .tick  (tick_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: exactly one step per tick; HALT is terminal until reset.
    always_comb begin
        state_next_s = state_r;
        if (tick_s) begin
            case (state_r)
                S_FETCH:  state_next_s = S_DECODE;
                S_DECODE: state_next_s = S_EXEC;
                S_EXEC:   state_next_s = (ir_op_r == OP_HALT) ? S_HALT : S_WB;
                S_WB:     state_next_s = S_FETCH;
                S_HALT:   state_next_s = S_HALT;
                default:  state_next_s = S_FETCH;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Datapath registers. Register addresses come straight from the ROM word so the
    // regfile has the whole DECODE step to return its one-clock-late read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address      <= {ADDR_W{1'b0}};
            reg_a        <= 3'd0;
            reg_b        <= 3'd0;
            write_enable <= 1'b0;
            write_data   <= {DATA_W{1'b0}};
            result       <= {DATA_W{1'b0}};
            halted       <= 1'b0;
            ir_op_r      <= 4'h0;
            ir_imm_r     <= 8'h00;
            opa_r        <= {DATA_W{1'b0}};
            opb_r        <= {DATA_W{1'b0}};
        end else begin
            write_enable <= 1'b0;
            if (tick_s) begin
                case (state_r)
                    S_FETCH: begin
                        ir_op_r  <= instruction[OP_HI:OP_LO];
                        ir_imm_r <= instruction[IMM_HI:IMM_LO];
                        reg_a    <= instruction[RA_HI:RA_LO];
                        reg_b    <= instruction[RB_HI:RB_LO];
                    end
                    S_DECODE: begin
                        opa_r <= data_a;
                        opb_r <= data_b;
                    end
                    S_EXEC: begin
                        case (ir_op_r)
                            OP_ADDI: begin
                                write_data   <= DATA_W'(ir_imm_r);
                                write_enable <= 1'b1;
                            end
                            OP_ADD: begin
                                write_data   <= opa_r + opb_r;
                                write_enable <= 1'b1;
                            end
                            OP_SUB: begin
                                write_data   <= opa_r - opb_r;
                                write_enable <= 1'b1;
                            end
                            OP_OUT:  result <= opa_r;
                            OP_HALT: halted <= 1'b1;
                            default: ;
                        endcase
                    end
                    S_WB:    address <= address + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign state_dbg = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with TICK_DIV=2 (8 clocks per instruction);
// models the instruction ROM and a register file with one-clock read latency.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] instruction;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [2:0]  address;
    logic [2:0]  reg_a;
    logic [2:0]  reg_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [15:0] result;
    logic        halted;
    logic [2:0]  state_dbg;

    logic [15:0] rom  [8];
    logic [15:0] regs [8];
    int          wtotal;
    int          wbase;
    int          checks;
    int          errors;

    instr_sequencer #(
        .TICK_DIV (2),
        .ADDR_W   (3),
        .DATA_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .instruction  (instruction),
        .data_a       (data_a),
        .data_b       (data_b),
        .address      (address),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .result       (result),
        .halted       (halted),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = rom[address];

    // Register file: synchronous write, registered (one clock late) read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
            data_a <= 16'h0000;
            data_b <= 16'h0000;
        end else begin
            if (write_enable) regs[reg_a] <= write_data;
            data_a <= regs[reg_a];
            data_b <= regs[reg_b];
        end
    end

    // Count clocks with write_enable high.
    initial wtotal = 0;
    always @(negedge clk) begin
        if (write_enable === 1'b1) wtotal <= wtotal + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_address", {29'd0, address}, 32'd0);
        check_eq("rst_we", {31'd0, write_enable}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;
        run   = 1'b1;
        wbase = wtotal;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        wbase  = 0;
        clear_rom();

        // T1: reset mid-WB drops write_enable immediately
        rom[0] = 16'h1205;
        do_reset();
        step(6);
        check_eq("t1_we_in_wb", {31'd0, write_enable}, 32'd1);
        check_eq("t1_state_wb", {29'd0, state_dbg}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t1_we_async", {31'd0, write_enable}, 32'd0);
        check_eq("t1_addr_async", {29'd0, address}, 32'd0);
        check_eq("t1_result_async", {16'd0, result}, 32'd0);
        check_eq("t1_state_async", {29'd0, state_dbg}, 32'd0);

        // T2: ADDI r1,5; ADDI r2,7; ADD r1,r2; OUT r1
        clear_rom();
        rom[0] = 16'h1205;
        rom[1] = 16'h1407;
        rom[2] = 16'h2280;
        rom[3] = 16'hF200;
        do_reset();
        step(29);
        check_eq("t2_result_before", {16'd0, result}, 32'd0);
        step(3);
        check_eq("t2_result", {16'd0, result}, 32'h000C);
        check_eq("t2_writes", wtotal - wbase, 32'd3);
        check_eq("t2_write_data", {16'd0, write_data}, 32'h000C);
        check_eq("t2_r1", {16'd0, regs[1]}, 32'h000C);

        // T3: ADDI r1,1; SUB r3,r1; OUT r3 -> wraps to 0xFFFF
        clear_rom();
        rom[0] = 16'h1201;
        rom[1] = 16'h3640;
        rom[2] = 16'hF600;
        do_reset();
        step(32);
        check_eq("t3_write_data", {16'd0, write_data}, 32'hFFFF);
        check_eq("t3_result", {16'd0, result}, 32'hFFFF);
        check_eq("t3_writes", wtotal - wbase, 32'd2);

        // T4: all NOPs, PC walks 0..7 and wraps
        clear_rom();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(8);
            check_eq("t4_address", {29'd0, address}, 32'(k % 8));
        end
        check_eq("t4_writes", wtotal - wbase, 32'd0);
        check_eq("t4_result", {16'd0, result}, 32'd0);

        // T5: HALT at address 2
        clear_rom();
        rom[2] = 16'hE000;
        do_reset();
        step(21);
        check_eq("t5_not_halted", {31'd0, halted}, 32'd0);
        step(1);
        check_eq("t5_halted", {31'd0, halted}, 32'd1);
        check_eq("t5_state", {29'd0, state_dbg}, 32'd4);
        step(100);
        check_eq("t5_address", {29'd0, address}, 32'd2);
        check_eq("t5_state_hold", {29'd0, state_dbg}, 32'd4);
        check_eq("t5_writes", wtotal - wbase, 32'd0);

        // T6: freeze during EXEC of ADD, including the cycle a tick would land
        clear_rom();
        rom[0] = 16'h1205;
        rom[1] = 16'h1407;
        rom[2] = 16'h2280;
        rom[3] = 16'hF200;
        do_reset();
        step(21);
        check_eq("t6_state_exec", {29'd0, state_dbg}, 32'd2);
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check_eq("t6_frozen", {29'd0, state_dbg}, 32'd2);
            check_eq("t6_we_frozen", {31'd0, write_enable}, 32'd0);
        end
        run = 1'b1;
        step(40);
        check_eq("t6_result", {16'd0, result}, 32'h000C);
        check_eq("t6_writes", wtotal - wbase, 32'd3);
        check_eq("t6_r1", {16'd0, regs[1]}, 32'h000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
